// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: machine widths,
//   access-size encodings and the responder state encoding.
//   No ports.
package dmem_responder_pkg;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Purely combinational byte-lane logic for one XLEN word.
//   Ports:
//     oldWord    in   current array word
//     wdata      in   right-aligned store data
//     size       in   access size (SIZE_B/SIZE_H/SIZE_W, 11 reserved)
//     addrLo     in   byte offset within the word
//     isUnsigned in   zero-extend sub-word loads
//     newWord    out  oldWord with the store lanes merged in
//     loadData   out  selected lanes, right-aligned and extended
//     misaligned out  misaligned access or reserved size
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] oldWord,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      size,
  input  logic [1:0]      addrLo,
  input  logic            isUnsigned,
  output logic [XLEN-1:0] newWord,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    newWord    = oldWord;
    loadData   = '0;
    shifted    = oldWord >> {addrLo, 3'b000};
    case (size)
      SIZE_B: begin
        newWord[{addrLo, 3'b000} +: 8] = wdata[7:0];
        loadData = isUnsigned ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        misaligned = addrLo[0];
        // Half lanes are chosen by addr[1] only; addr[0] just flags misalignment.
        newWord[{addrLo[1], 4'b0000} +: 16] = wdata[15:0];
        loadData = isUnsigned ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        misaligned = (addrLo != 2'b00);
        newWord    = wdata;
        loadData   = oldWord;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the pipeline data-memory port. Accepts one
//   load/store through a valid/ready handshake, holds it for WAIT_CYCLES wait
//   states, commits stores with byte-lane merge, then pulses one response.
//   Optional macro DMEM_STORE_TRACE_EN: prints a trace line for each
//   committed store (simulation only; req_pc unused otherwise).
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     req_valid/req_ready             request handshake
//     req_we, req_addr, req_wdata     store flag, byte address, store data
//     req_size, req_unsigned          access size, zero-extend loads
//     req_pc                          requesting pc (trace only)
//     resp_valid, resp_rdata, resp_err  one-cycle response
module dmem_responder #(
  parameter int XLEN        = dmem_responder_pkg::XLEN,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  import dmem_responder_pkg::*;

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmemState_t      state;
  logic [3:0]      cnt;
  logic            reqReadyQ, respValidQ, respErrQ;
  logic [XLEN-1:0] respRdataQ;

  logic            latWe, latUns;
  logic [XLEN-1:0] latAddr, latWdata;
  logic [1:0]      latSize;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            inIdle, accept, enterResp, commit, misaligned;
  logic            actWe, actUns;
  logic [XLEN-1:0] actAddr, actWdata, oldWord, newWord, loadData;
  logic [1:0]      actSize;
  logic [IDX_W-1:0] idx;

  assign inIdle = (state == IDLE);
  assign accept = req_valid && reqReadyQ;

  // With zero wait states the commit/read happens on the accept edge itself,
  // so the live request fields feed the lane logic while idle.
  assign actWe    = inIdle ? req_we       : latWe;
  assign actAddr  = inIdle ? req_addr     : latAddr;
  assign actWdata = inIdle ? req_wdata    : latWdata;
  assign actSize  = inIdle ? req_size     : latSize;
  assign actUns   = inIdle ? req_unsigned : latUns;

  assign idx     = actAddr[IDX_W+1:2];
  assign oldWord = mem[idx];

  assign enterResp = (ZERO_WAIT && inIdle && accept) || (state == WAIT && cnt == 4'd0);
  assign commit    = enterResp && actWe && !misaligned;

  dmem_lane_align uAlign (
    .oldWord    (oldWord),
    .wdata      (actWdata),
    .size       (actSize),
    .addrLo     (actAddr[1:0]),
    .isUnsigned (actUns),
    .newWord    (newWord),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!reset && commit) mem[idx] <= newWord;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      reqReadyQ  <= 1'b1;
      respValidQ <= 1'b0;
      respErrQ   <= 1'b0;
      respRdataQ <= '0;
    end else begin
      respValidQ <= 1'b0;
      respErrQ   <= 1'b0;
      respRdataQ <= '0;
      case (state)
        IDLE: if (accept) begin
          latWe     <= req_we;
          latAddr   <= req_addr;
          latWdata  <= req_wdata;
          latSize   <= req_size;
          latUns    <= req_unsigned;
          reqReadyQ <= 1'b0;
          if (ZERO_WAIT) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP: begin
          state     <= IDLE;
          reqReadyQ <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          reqReadyQ <= 1'b1;
        end
      endcase
      if (enterResp) begin
        respValidQ <= 1'b1;
        respErrQ   <= misaligned;
        respRdataQ <= (actWe || misaligned) ? '0 : loadData;
      end
    end
  end

  assign req_ready  = reqReadyQ;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign resp_err   = respErrQ;

`ifdef DMEM_STORE_TRACE_EN
  logic [XLEN-1:0] latPc;
  logic            unusedBits;
  assign unusedBits = ^actAddr[XLEN-1:IDX_W+2];

  always_ff @(posedge clk) begin
    if (!reset && inIdle && accept) latPc <= req_pc;
    if (!reset && commit)
      $display("pc = %h: dataaddr = %h, memdata = %h",
               inIdle ? req_pc : latPc, actAddr, newWord);
  end
`else
  // Address bits above the array index wrap away; req_pc feeds nothing.
  logic unusedBits;
  assign unusedBits = ^{actAddr[XLEN-1:IDX_W+2], req_pc};
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts load/store requests (address, write data, size, signedness) through a valid/ready handshake.
- Holds each request for a programmable number of wait states, commits stores with byte-lane merge, then returns one response carrying sign/zero-extended load data and a misalignment error flag.
- Replaces the zero-latency array so the pipeline can later be exercised against a slow memory.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, number of XLEN-bit words in the array; power of two.
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 = reserved, treated as error.
- req_unsigned  in  1  zero-extend load data (lbu/lhu).
- req_pc  in  XLEN  pc of the requesting instruction; used by the trace feature only.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request.

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a clock edge where req_valid && req_ready.
- On accept, all req_* fields are latched; later changes to the inputs are ignored.
- Transition out of IDLE: to WAIT with the counter loaded to WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES = 0.
- WAIT: the counter decrements each cycle; at 0 the block moves to RESP on the next edge.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
- RESP lasts exactly one cycle, then returns to IDLE.
- There is no back-pressure on the response; the requester must take it.
- Back-to-back throughput: one request per WAIT_CYCLES+2 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo the array size.
- Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0) or req_size = 11:
  - resp_err = 1, resp_rdata = 0.
  - No array write.
- Store commit:
  - Happens on the edge entering RESP; the array is unchanged before that edge.
  - Byte store writes lane addr[1:0]. Half store writes lanes {addr[1], 0} and {addr[1], 1}. Word store writes all lanes.
  - Untouched lanes keep their old value.
- Load:
  - The word is read on the edge entering RESP.
  - The selected lane(s) are right-aligned.
  - Sign-extended unless req_unsigned = 1.
  - Word loads ignore req_unsigned.
- A load immediately after a store to the same word sees the stored data, because the commit precedes the next accept.
- Reset values: state = IDLE, counter = 0, req_ready = 1 from the first cycle after reset, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Array contents are not reset.
- Reset mid-operation: a pending request is dropped; an uncommitted store never reaches the array; no response is issued.
- reset and req_valid asserted together: reset wins, nothing is accepted.

Optional Feature:
- Macro: DMEM_STORE_TRACE_EN.
- With the macro defined: each committed non-error store prints "pc = <req_pc hex>: dataaddr = <addr hex>, memdata = <merged word hex>" via $display on the commit edge.
- Without the macro: no simulation output, and req_pc is unused (left unconnected, no logic generated).
- Synthesised hardware is identical in both cases.

Decomposition:
- Shared package / defines header holds:
  - size encodings SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10;
  - state encoding IDLE/WAIT/RESP;
  - XLEN and ADDR_SIZE reused from the existing defines.
- One natural sub-module: dmem_lane_align, purely combinational, containing:
  - store byte-lane merge (old word, wdata, size, addr[1:0] -> new word);
  - load extract and extend (word, size, addr[1:0], unsigned -> rdata);
  - misalignment detection.

Test Plan:
- Word round trip, WAIT_CYCLES = 2: store 0xDEADBEEF @0x10 -> resp_valid exactly 3 cycles after accept, err = 0; then load word @0x10 -> rdata 0xDEADBEEF.
- Byte merge: after the above, sb 0x7F @0x12 -> load word @0x10 = 0xDE7FBEEF; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
- Half access: sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001; lh @0x21 -> err = 1, rdata 0, word @0x20 unchanged.
- Handshake: hold req_valid high continuously -> req_ready low during WAIT/RESP, exactly one accept per 4 cycles; changing req_addr mid-WAIT does not alter the response.
- Reset mid-WAIT: store 0x12345678 @0x40, assert reset in the WAIT cycle -> no resp_valid, load @0x40 returns the prior value; req_ready = 1 from the cycle after reset.
- WAIT_CYCLES = 0 build and wrap: store 0xA5A5A5A5 @(DEPTH_WORDS*4 + 0x8) -> response 1 cycle after accept; load @0x8 -> 0xA5A5A5A5.
